// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the AHB-to-APB bridge controller.
// Holds the bus widths, the FSM state encoding, the one-hot slave select
// codes and the address region / slave field positions used by the decoder.
package apb_ctrl_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;
  localparam logic [SEL_W-1:0] SEL_S0   = 3'b001;
  localparam logic [SEL_W-1:0] SEL_S1   = 3'b010;
  localparam logic [SEL_W-1:0] SEL_S2   = 3'b100;

  // Bridge region lives in the top nibble; the next two bits pick the slave.
  localparam logic [3:0]  REGION_BASE = 4'h8;
  localparam int unsigned REGION_MSB  = 31;
  localparam int unsigned REGION_LSB  = 28;
  localparam int unsigned SLAVE_MSB   = 27;
  localparam int unsigned SLAVE_LSB   = 26;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB slave decoder.
// Ports:
//   i_addr   - AHB address (address phase)
//   o_sel_c  - one-hot slave select, SEL_NONE on a miss
//   o_miss_c - 1 when the address is outside the bridge region or slave 3
module apb_addr_decoder
  import apb_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  output logic [SEL_W-1:0]  o_sel_c,
  output logic              o_miss_c
);

  logic [3:0] w_region;
  logic [1:0] w_slave;
  logic       w_unused_low;

  assign w_region     = i_addr[REGION_MSB:REGION_LSB];
  assign w_slave      = i_addr[SLAVE_MSB:SLAVE_LSB];
  // Offset bits within a slave window play no part in the decode.
  assign w_unused_low = ^i_addr[SLAVE_LSB-1:0];

  // Slave field 2'b11 is unpopulated and decodes as a miss.
  always_comb begin
    o_sel_c = SEL_NONE;
    if (w_region == REGION_BASE) begin
      case (w_slave)
        2'b00:   o_sel_c = SEL_S0;
        2'b01:   o_sel_c = SEL_S1;
        2'b10:   o_sel_c = SEL_S2;
        default: o_sel_c = SEL_NONE;
      endcase
    end
    o_miss_c = (o_sel_c == SEL_NONE);
  end

endmodule

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge controller FSM.
// Converts single AHB transfers into APB SETUP/ACCESS cycles, inserts a
// write-data wait state, aborts stalled slaves after TIMEOUT ACCESS cycles
// and returns a two-cycle AHB ERROR for timeouts and decode misses.
// Ports:
//   Hclk, Hresetn        - clock, synchronous active-low reset
//   valid/Haddr/Hwrite   - AHB address phase (valid qualified by Hreadyout)
//   Hwdata               - AHB write data (data phase)
//   Prdata/Pready        - APB slave response
//   Pselx..Penable       - registered APB request
//   Hreadyout/Hrdata/Hresp - AHB response, combinational from state/Pready
module apb_fsm_controller
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  output logic [SEL_W-1:0]  Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hresp
);

  localparam logic [STATE_W-1:0] S_IDLE   = ST_IDLE;
  localparam logic [STATE_W-1:0] S_WWAIT  = ST_WWAIT;
  localparam logic [STATE_W-1:0] S_SETUP  = ST_SETUP;
  localparam logic [STATE_W-1:0] S_ACCESS = ST_ACCESS;
  localparam logic [STATE_W-1:0] S_ERR1   = ST_ERR1;
  localparam logic [STATE_W-1:0] S_ERR2   = ST_ERR2;

  // A zero TIMEOUT still needs a one-bit counter to keep the logic legal.
  localparam int unsigned     CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_pselx, w_pselx_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [ADDR_W-1:0]  r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]  r_pwdata, w_pwdata_nxt;
  logic               r_pwrite, w_pwrite_nxt;
  logic               r_penable, w_penable_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_accept;
  logic [SEL_W-1:0]   w_dec_sel;
  logic               w_dec_miss;

  apb_addr_decoder u_dec (
    .i_addr   (Haddr),
    .o_sel_c  (w_dec_sel),
    .o_miss_c (w_dec_miss)
  );

  // State and registered APB outputs.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_state   <= S_IDLE;
      r_pselx   <= SEL_NONE;
      r_sel     <= SEL_NONE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_penable <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pselx   <= w_pselx_nxt;
      r_sel     <= w_sel_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_penable <= w_penable_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Next state and next APB outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_pselx_nxt   = r_pselx;
    w_sel_nxt     = r_sel;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_pwrite_nxt  = r_pwrite;
    w_penable_nxt = r_penable;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;

    case (r_state)
      S_IDLE: w_accept = 1'b1;
      S_WWAIT: begin
        w_pwdata_nxt = Hwdata;
        w_pselx_nxt  = r_sel;
        w_state_nxt  = S_SETUP;
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (Pready) begin
          w_accept = 1'b1;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_pselx_nxt   = SEL_NONE;
          w_penable_nxt = 1'b0;
          w_state_nxt   = S_ERR1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      S_ERR2:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Address-phase acceptance, shared by IDLE and a completing ACCESS so
    // back-to-back transfers skip the IDLE cycle.
    if (w_accept) begin
      w_pselx_nxt   = SEL_NONE;
      w_penable_nxt = 1'b0;
      w_state_nxt   = S_IDLE;
      if (valid) begin
        w_paddr_nxt  = Haddr;
        w_pwrite_nxt = Hwrite;
        w_sel_nxt    = w_dec_sel;
        if (w_dec_miss) begin
          w_state_nxt = S_ERR1;
        end else if (Hwrite) begin
          w_state_nxt = S_WWAIT;
        end else begin
          w_pselx_nxt = w_dec_sel;
          w_state_nxt = S_SETUP;
        end
      end
    end
  end

  assign Pselx   = r_pselx;
  assign Paddr   = r_paddr;
  assign Pwdata  = r_pwdata;
  assign Pwrite  = r_pwrite;
  assign Penable = r_penable;

  assign Hreadyout = (r_state == S_IDLE) || (r_state == S_ERR2) ||
                     ((r_state == S_ACCESS) && Pready);
  assign Hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign Hrdata    = ((r_state == S_ACCESS) && !r_pwrite && Pready) ? Prdata : '0;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: directed vector table,
// hand-written back-to-back and reset sequences, and random transfers
// checked against a transaction-level reference model.
module tb_apb_fsm_controller;

  localparam int unsigned TIMEOUT = 16;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        valid;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic        Penable;
  logic        Hreadyout;
  logic [31:0] Hrdata;
  logic        Hresp;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Hclk = ~Hclk;

  apb_fsm_controller #(.TIMEOUT(TIMEOUT)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .valid     (valid),
    .Haddr     (Haddr),
    .Hwrite    (Hwrite),
    .Hwdata    (Hwdata),
    .Prdata    (Prdata),
    .Pready    (Pready),
    .Pselx     (Pselx),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Hreadyout (Hreadyout),
    .Hrdata    (Hrdata),
    .Hresp     (Hresp)
  );

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic [2:0]  esel;   // expected select, 0 on decode miss
    bit          eerr;   // transfer ends in the two-cycle error
    int          elat;   // cycles after address phase to completion / ERR1
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge Hclk);
    #1;
  endtask

  task automatic smp();
    @(negedge Hclk);
  endtask

  task automatic expect_cyc(input string name, input logic [2:0] sel, input bit pen,
                            input bit hready, input bit hresp, input logic [31:0] hrdata);
    chk({name, " Pselx"}, 32'(Pselx), 32'(sel));
    chk({name, " Penable"}, 32'(Penable), 32'(pen));
    chk({name, " Hreadyout"}, 32'(Hreadyout), 32'(hready));
    chk({name, " Hresp"}, 32'(Hresp), 32'(hresp));
    chk({name, " Hrdata"}, Hrdata, hrdata);
  endtask

  task automatic expect_req(input string name, input logic [31:0] addr, input bit wr,
                            input logic [31:0] wdata);
    chk({name, " Paddr"}, Paddr, addr);
    chk({name, " Pwrite"}, 32'(Pwrite), 32'(wr));
    if (wr) chk({name, " Pwdata"}, Pwdata, wdata);
  endtask

  // Spec-level model: region nibble 8, slave field 0..2 selects 1<<field;
  // read = address, SETUP, ACCESS; write adds a data-phase cycle; each slave
  // wait adds one ACCESS cycle until TIMEOUT low cycles force the error.
  function automatic void ref_model(input logic [31:0] addr, input bit wr, input int waits,
                                    output logic [2:0] esel, output bit eerr, output int elat);
    int nib;
    int fld;
    int base;
    nib = int'(addr >> 28);
    fld = int'((addr >> 26) & 32'h3);
    if (nib == 8 && fld < 3) begin
      esel = 3'(1 << fld);
      base = wr ? 3 : 2;
      if (TIMEOUT > 0 && waits >= int'(TIMEOUT)) begin
        eerr = 1'b1;
        elat = base + int'(TIMEOUT);
      end else begin
        eerr = 1'b0;
        elat = base + waits;
      end
    end else begin
      esel = 3'b000;
      eerr = 1'b1;
      elat = 1;
    end
  endfunction

  // One isolated transfer from IDLE, checked every cycle until back in IDLE.
  task automatic do_txn(input string tag, input vec_t v);
    int acc0;
    int acc_end;
    int last;
    bit in_apb;
    acc0    = v.wr ? 3 : 2;
    acc_end = v.eerr ? v.elat - 1 : v.elat;
    last    = v.eerr ? v.elat + 2 : v.elat + 1;
    cyc();
    valid  = 1'b1;
    Haddr  = v.addr;
    Hwrite = v.wr;
    Hwdata = $urandom;
    Prdata = $urandom;
    Pready = 1'($urandom_range(0, 1));
    smp();
    expect_cyc({tag, " addr"}, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int c = 1; c <= last; c++) begin
      cyc();
      valid  = 1'b0;
      Haddr  = $urandom;
      Hwrite = 1'($urandom_range(0, 1));
      Hwdata = (c == 1) ? v.wdata : $urandom;
      Prdata = (!v.eerr && c == v.elat) ? v.prdata : $urandom;
      if (v.esel != 3'b000 && c >= acc0 && c <= acc_end) Pready = ((c - acc0) >= v.waits);
      else Pready = 1'($urandom_range(0, 1));
      smp();
      if (c < v.elat) begin
        in_apb = !(v.wr && c == 1);
        expect_cyc($sformatf("%s c%0d", tag, c), in_apb ? v.esel : 3'b000, c >= acc0,
                   1'b0, 1'b0, 32'h0);
        if (in_apb) expect_req($sformatf("%s c%0d", tag, c), v.addr, v.wr, v.wdata);
      end else if (c == v.elat && !v.eerr) begin
        expect_cyc({tag, " done"}, v.esel, 1'b1, 1'b1, 1'b0, v.wr ? 32'h0 : v.prdata);
        expect_req({tag, " done"}, v.addr, v.wr, v.wdata);
      end else if (c == v.elat) begin
        expect_cyc({tag, " err1"}, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0);
      end else if (v.eerr && c == v.elat + 1) begin
        expect_cyc({tag, " err2"}, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0);
      end else begin
        expect_cyc({tag, " idle"}, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
      end
    end
  endtask

  initial begin
    vec_t rv;
    // addr, wr, wdata, prdata, waits, esel, eerr, elat
    vt[0] = '{32'h8000_0010, 1'b0, 32'h0,         32'h19,        0,  3'b001, 1'b0, 2};
    vt[1] = '{32'h8400_0004, 1'b1, 32'hDEAD_BEEF, 32'h0,         0,  3'b010, 1'b0, 3};
    vt[2] = '{32'h8800_0000, 1'b0, 32'h0,         32'h0000_CAFE, 3,  3'b100, 1'b0, 5};
    vt[3] = '{32'h8800_0040, 1'b0, 32'h0,         32'h5555_AAAA, 16, 3'b100, 1'b1, 18};
    vt[4] = '{32'h8C00_0000, 1'b0, 32'h0,         32'h1,         0,  3'b000, 1'b1, 1};
    vt[5] = '{32'h1000_0000, 1'b1, 32'h1234_5678, 32'h0,         0,  3'b000, 1'b1, 1};
    vt[6] = '{32'h8000_0100, 1'b1, 32'h0BAD_F00D, 32'h0,         15, 3'b001, 1'b0, 18};
    vt[7] = '{32'h8400_0000, 1'b1, 32'hFACE_0001, 32'h0,         20, 3'b010, 1'b1, 19};
    vt[8] = '{32'h9000_0000, 1'b0, 32'h0,         32'h7,         0,  3'b000, 1'b1, 1};

    // Reset with a pending transfer on the bus: reset must win.
    Hresetn = 1'b0;
    valid   = 1'b1;
    Haddr   = 32'h8000_0000;
    Hwrite  = 1'b1;
    Hwdata  = 32'hFFFF_FFFF;
    Prdata  = 32'hFFFF_FFFF;
    Pready  = 1'b1;
    cyc();
    cyc();
    smp();
    expect_cyc("reset", 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_req("reset", 32'h0, 1'b0, 32'h0);
    chk("reset Pwdata", Pwdata, 32'h0);
    cyc();
    Hresetn = 1'b1;
    valid   = 1'b0;
    smp();

    for (int i = 0; i < 9; i++) do_txn($sformatf("vec%0d", i), vt[i]);

    // Back-to-back: read completes while a write is presented, then a miss.
    cyc(); valid = 1'b1; Haddr = 32'h8000_0020; Hwrite = 1'b0; Pready = 1'b0; smp();
    expect_cyc("b2b t0", 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(); valid = 1'b0; smp();
    expect_cyc("b2b rd setup", 3'b001, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(); valid = 1'b1; Haddr = 32'h8400_0008; Hwrite = 1'b1; Pready = 1'b1;
    Prdata = 32'h1234_5678; smp();
    expect_cyc("b2b rd done", 3'b001, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    cyc(); valid = 1'b0; Hwdata = 32'hA5A5_0F0F; smp();
    expect_cyc("b2b wwait", 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(); Hwdata = $urandom; smp();
    expect_cyc("b2b wr setup", 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_req("b2b wr setup", 32'h8400_0008, 1'b1, 32'hA5A5_0F0F);
    cyc(); valid = 1'b1; Haddr = 32'h8C00_0000; Hwrite = 1'b0; smp();
    expect_cyc("b2b wr done", 3'b010, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc(); valid = 1'b0; smp();
    expect_cyc("b2b err1", 3'b000, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc(); smp();
    expect_cyc("b2b err2", 3'b000, 1'b0, 1'b1, 1'b1, 32'h0);
    cyc(); smp();
    expect_cyc("b2b idle", 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);

    // One-cycle reset in the middle of a stalled write ACCESS.
    cyc(); valid = 1'b1; Haddr = 32'h8400_0004; Hwrite = 1'b1; Pready = 1'b0; smp();
    cyc(); valid = 1'b0; Hwdata = 32'hDEAD_BEEF; smp();
    cyc(); smp();
    cyc(); smp();
    expect_cyc("rst access", 3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
    Hresetn = 1'b0;
    cyc(); Hresetn = 1'b1; smp();
    expect_cyc("rst abort", 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_req("rst abort", 32'h0, 1'b0, 32'h0);
    chk("rst abort Pwdata", Pwdata, 32'h0);

    // Random transfers against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] nib;
      logic [1:0] fld;
      nib = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h8;
      fld = 2'($urandom);
      rv.addr   = {nib, fld, 26'($urandom)};
      rv.wr     = 1'($urandom_range(0, 1));
      rv.wdata  = $urandom;
      rv.prdata = $urandom;
      rv.waits  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20))
                                             : int'($urandom_range(0, 5));
      ref_model(rv.addr, rv.wr, rv.waits, rv.esel, rv.eerr, rv.elat);
      do_txn($sformatf("rnd%0d", i), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
